// File: rtl/buzz_pkg.sv
// Purpose: shared types and default constants for the buzzer tone-line receivers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package buzz_pkg;

    // Receiver decode state: waiting for tone, inside a beep, between beeps of a burst
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } buzz_state_t;

    // Defaults sized for a ~1 kHz-class tone on a fast core clock
    localparam int TONE_TO_DEF  = 32768;
    localparam int MIN_BEEP_DEF = 1024;
    localparam int BURST_TO_DEF = 33554432;

    // Metastability depth of the tone-line synchronizer
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/buzz_edge_sync.sv
// Purpose: synchronizes an asynchronous line and flags every level change as a one-cycle edge strobe.
// Latency: a pin change shows up as edge_stb 3 clocks later (sampled on the 3rd rising edge).
// Backpressure: none; free-running strobe, every change produces exactly one strobe.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   din       asynchronous input line (idle high)
//   edge_stb  one-cycle strobe per synchronized level change
module buzz_edge_sync
    import buzz_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_stb
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Everything resets to the idle-high level so that releasing reset on an
    // idle line never looks like a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_stb = hist_q ^ sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/buzz_monitor.sv
// Purpose: decodes an active-low square-wave tone line into accepted beeps and per-burst beep counts.
// Latency: edge seen 3 clocks after the pin; beep_pulse TONE_TO clocks after the last edge; burst_valid BURST_TO clocks later.
// Backpressure: none; strobes are single-cycle and must be captured by the consumer when they fire.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   beep_n       asynchronous tone line, idle high
//   tone_active  high while a tone is in progress
//   beep_pulse   one-cycle strobe per accepted beep
//   burst_valid  one-cycle strobe when a burst with at least one beep ends
//   burst_count  beeps in the last completed burst (saturating), held until next burst_valid
//   tone_period  last measured edge-to-edge half-period; built only with BUZZ_MON_PERIOD_EN, else 0
module buzz_monitor
    import buzz_pkg::*;
#(
    parameter int TONE_TO  = TONE_TO_DEF,
    parameter int MIN_BEEP = MIN_BEEP_DEF,
    parameter int BURST_TO = BURST_TO_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beep_n,
    output logic             tone_active,
    output logic             beep_pulse,
    output logic             burst_valid,
    output logic [CNT_W-1:0] burst_count,
    output logic [15:0]      tone_period
);

    localparam int TT_W   = $clog2(TONE_TO);
    localparam int BT_W   = $clog2(BURST_TO);
    localparam int SPAN_W = $clog2(MIN_BEEP + 1);

    localparam logic [TT_W-1:0]   TONE_LAST  = TT_W'(TONE_TO - 1);
    localparam logic [BT_W-1:0]   BURST_LAST = BT_W'(BURST_TO - 1);
    // Span only has to prove "long enough", so it stops counting at MIN_BEEP
    localparam logic [SPAN_W-1:0] SPAN_MAX   = SPAN_W'(MIN_BEEP);

    logic edge_stb;

    buzz_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (beep_n),
        .edge_stb (edge_stb)
    );

    buzz_state_t       state_q, state_d;
    logic [TT_W-1:0]   tone_tmr_q, tone_tmr_d;
    logic [BT_W-1:0]   gap_tmr_q, gap_tmr_d;
    logic [SPAN_W-1:0] span_q, span_d, span_inc;
    logic [SPAN_W-1:0] beep_len_q, beep_len_d;
    logic [CNT_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic [CNT_W-1:0]  burst_count_q, burst_count_d;
    logic              beep_pulse_q, beep_pulse_d;
    logic              burst_valid_q, burst_valid_d;
    logic              tone_active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tone_tmr_q    <= '0;
            gap_tmr_q     <= '0;
            span_q        <= '0;
            beep_len_q    <= '0;
            beep_cnt_q    <= '0;
            burst_count_q <= '0;
            beep_pulse_q  <= 1'b0;
            burst_valid_q <= 1'b0;
            tone_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tone_tmr_q    <= tone_tmr_d;
            gap_tmr_q     <= gap_tmr_d;
            span_q        <= span_d;
            beep_len_q    <= beep_len_d;
            beep_cnt_q    <= beep_cnt_d;
            burst_count_q <= burst_count_d;
            beep_pulse_q  <= beep_pulse_d;
            burst_valid_q <= burst_valid_d;
            tone_active_q <= (state_d == TONE);
        end
    end

    always_comb begin
        state_d       = state_q;
        tone_tmr_d    = tone_tmr_q;
        gap_tmr_d     = gap_tmr_q;
        span_d        = span_q;
        beep_len_d    = beep_len_q;
        beep_cnt_d    = beep_cnt_q;
        burst_count_d = burst_count_q;
        beep_pulse_d  = 1'b0;
        burst_valid_d = 1'b0;
        span_inc      = (span_q == SPAN_MAX) ? span_q : span_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (edge_stb) begin
                    state_d    = TONE;
                    tone_tmr_d = '0;
                    span_d     = '0;
                    beep_len_d = '0;
                end
            end
            TONE: begin
                span_d = span_inc;
                // An edge on the expiry cycle keeps the beep alive
                if (edge_stb) begin
                    tone_tmr_d = '0;
                    // Length runs from the first edge to this one
                    beep_len_d = span_inc;
                end else if (tone_tmr_q == TONE_LAST) begin
                    state_d   = GAP;
                    gap_tmr_d = '0;
                    if (beep_len_q >= SPAN_MAX) begin
                        beep_pulse_d = 1'b1;
                        if (beep_cnt_q != {CNT_W{1'b1}}) begin
                            beep_cnt_d = beep_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    tone_tmr_d = tone_tmr_q + 1'b1;
                end
            end
            GAP: begin
                if (edge_stb) begin
                    // Next beep of the same burst starts fresh
                    state_d    = TONE;
                    gap_tmr_d  = '0;
                    tone_tmr_d = '0;
                    span_d     = '0;
                    beep_len_d = '0;
                end else if (gap_tmr_q == BURST_LAST) begin
                    state_d    = IDLE;
                    beep_cnt_d = '0;
                    if (beep_cnt_q != '0) begin
                        burst_count_d = beep_cnt_q;
                        burst_valid_d = 1'b1;
                    end
                end else begin
                    gap_tmr_d = gap_tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tone_active = tone_active_q;
    assign beep_pulse  = beep_pulse_q;
    assign burst_valid = burst_valid_q;
    assign burst_count = burst_count_q;

`ifdef BUZZ_MON_PERIOD_EN
    logic [15:0] per_cnt_q;
    logic [15:0] tone_period_q;

    // per_cnt restarts at 1 on every edge so the value loaded at the next
    // edge equals the number of clocks between the two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q     <= '0;
            tone_period_q <= '0;
        end else if (state_q == TONE) begin
            if (edge_stb) begin
                tone_period_q <= per_cnt_q;
                per_cnt_q     <= 16'd1;
            end else if (per_cnt_q != 16'hFFFF) begin
                per_cnt_q <= per_cnt_q + 16'd1;
            end
        end else if (edge_stb) begin
            per_cnt_q <= 16'd1;
        end
    end

    assign tone_period = tone_period_q;
`else
    assign tone_period = '0;
`endif

endmodule

// File: tb/tb_buzz_monitor.sv
module tb_buzz_monitor;

    localparam int TONE_TO  = 16;
    localparam int MIN_BEEP = 8;
    localparam int BURST_TO = 64;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int TAIL     = TONE_TO + BURST_TO + 10;
    localparam int NO_CUT   = 32'h7fffffff;
`ifdef BUZZ_MON_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             beep_n = 1'b1;
    logic             tone_active;
    logic             beep_pulse;
    logic             burst_valid;
    logic [CNT_W-1:0] burst_count;
    logic [15:0]      tone_period;

    buzz_monitor #(
        .TONE_TO  (TONE_TO),
        .MIN_BEEP (MIN_BEEP),
        .BURST_TO (BURST_TO),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .beep_n      (beep_n),
        .tone_active (tone_active),
        .beep_pulse  (beep_pulse),
        .burst_valid (burst_valid),
        .burst_count (burst_count),
        .tone_period (tone_period)
    );

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard queues (times are cyc values at which the DUT output is visible)
    int exp_beep[$];
    int exp_burst_t[$];
    int exp_burst_c[$];
    int exp_rise[$];
    int exp_fall[$];
    int exp_held = 0;
    int per_exp  = 0;

    int gap_q[$];   // toggle-to-toggle intervals of the next phase
    int edge_q[$];  // cycles at which the DUT samples each edge

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_pending(input string name, input int pending);
        n_chk++;
        if (pending == 0) begin
            n_err++;
            $display("FAIL %s: DUT strobe at cycle %0d, required none", name, cyc);
        end
    endtask

    // Reference: group edges into beeps (edge spacing <= TONE_TO) and beeps
    // into bursts (next beep starts within BURST_TO after the beep ended).
    task automatic model(input int cut);
        int n;
        int i;
        int j;
        int first;
        int x;
        int cnt;
        n = edge_q.size();
        i = 0;
        cnt = 0;
        while (i < n) begin
            first = edge_q[i];
            j = i;
            while (j + 1 < n && edge_q[j+1] - edge_q[j] <= TONE_TO) j++;
            x = edge_q[j] + TONE_TO;
            if (j > i && edge_q[j] < cut) per_exp = edge_q[j] - edge_q[j-1];
            if (x < cut) begin
                exp_rise.push_back(first);
                exp_fall.push_back(x);
                if (edge_q[j] - first >= MIN_BEEP) begin
                    exp_beep.push_back(x);
                    if (cnt < CNT_MAX) cnt++;
                end
            end
            i = j + 1;
            if (!(i < n && edge_q[i] <= x + BURST_TO)) begin
                if (cnt > 0 && x + BURST_TO < cut) begin
                    exp_burst_t.push_back(x + BURST_TO);
                    exp_burst_c.push_back(cnt);
                    exp_held = cnt;
                end
                cnt = 0;
            end
        end
    endtask

    task automatic add_beep(input int lead, input int ntog, input int step);
        gap_q.push_back(lead);
        for (int k = 1; k < ntog; k++) gap_q.push_back(step);
    endtask

    // Called at #1 after a rising edge; predicts, then drives the toggles.
    task automatic run_phase(input int tail, input int cut_after);
        int t;
        int cut;
        t = cyc;
        edge_q.delete();
        foreach (gap_q[k]) begin
            t += gap_q[k];
            edge_q.push_back(t + 3);
        end
        cut = (cut_after < 0) ? NO_CUT : t + cut_after;
        model(cut);
        foreach (gap_q[k]) begin
            repeat (gap_q[k]) @(posedge clk);
            #1;
            beep_n = ~beep_n;
        end
        gap_q.delete();
        repeat (tail) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_beeps_missing"}, exp_beep.size(), 0);
        check({tag, "_bursts_missing"}, exp_burst_t.size(), 0);
        check({tag, "_tones_missing"}, exp_fall.size(), 0);
        check({tag, "_held_count"}, int'(burst_count), exp_held);
        check({tag, "_tone_period"}, int'(tone_period), PER_EN ? per_exp : 0);
        exp_beep.delete();
        exp_burst_t.delete();
        exp_burst_c.delete();
        exp_rise.delete();
        exp_fall.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tone_active"}, int'(tone_active), 0);
        check({tag, "_beep_pulse"}, int'(beep_pulse), 0);
        check({tag, "_burst_valid"}, int'(burst_valid), 0);
        check({tag, "_burst_count"}, int'(burst_count), 0);
        check({tag, "_tone_period"}, int'(tone_period), 0);
    endtask

    task automatic monitor();
        logic ta_prev;
        ta_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ta_prev = 1'b0;
            end else begin
                if (beep_pulse) begin
                    check_pending("beep_unexpected", exp_beep.size());
                    if (exp_beep.size() != 0) check("beep_cycle", cyc, exp_beep.pop_front());
                end
                if (burst_valid) begin
                    check_pending("burst_unexpected", exp_burst_t.size());
                    if (exp_burst_t.size() != 0) begin
                        check("burst_cycle", cyc, exp_burst_t.pop_front());
                        check("burst_count", int'(burst_count), exp_burst_c.pop_front());
                    end
                end
                if (tone_active && !ta_prev) begin
                    check_pending("tone_rise_unexpected", exp_rise.size());
                    if (exp_rise.size() != 0) check("tone_rise", cyc, exp_rise.pop_front());
                end
                if (!tone_active && ta_prev) begin
                    check_pending("tone_fall_unexpected", exp_fall.size());
                    if (exp_fall.size() != 0) check("tone_fall", cyc, exp_fall.pop_front());
                end
                ta_prev = tone_active;
            end
        end
    endtask

    initial begin
        int r;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;

        // Three 40-cycle beeps toggling every 4 cycles, 30 cycles apart
        add_beep(2, 10, 4);
        add_beep(34, 10, 4);
        add_beep(34, 10, 4);
        run_phase(TAIL, -1);
        end_checks("three_beeps");
        check("three_beeps_count", int'(burst_count), 3);
        check("three_beeps_period", int'(tone_period), PER_EN ? 4 : 0);

        // Isolated glitch edge: short tone, nothing reported
        add_beep(5, 1, 4);
        run_phase(TAIL, -1);
        end_checks("glitch");
        check("glitch_count_kept", int'(burst_count), 3);

        // Twenty accepted beeps saturate the counter
        for (int k = 0; k < 20; k++) add_beep((k == 0) ? 5 : 30, 4, 4);
        run_phase(TAIL, -1);
        end_checks("twenty");
        check("twenty_saturated", int'(burst_count), CNT_MAX);

        // Edge exactly on tone expiry, edge exactly on gap expiry, span exactly MIN_BEEP,
        // then a too-short beep one cycle past the burst limit
        gap_q = '{2, 16, 16, 80, 4, 4, 81, 4};
        run_phase(TAIL, -1);
        end_checks("boundary");
        check("boundary_count", int'(burst_count), 2);

        // Random bursts
        for (int rnd = 0; rnd < 5; rnd++) begin
            int nb;
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                add_beep((b == 0) ? 5 : $urandom_range(17, 100),
                         $urandom_range(1, 5), $urandom_range(1, 18));
            end
            run_phase(TAIL, -1);
            end_checks("random");
        end

        // Reset in the gap after two beeps: outputs drop immediately, no burst
        add_beep(3, 6, 4);
        add_beep(30, 6, 4);
        run_phase(40, 40);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        check("async_reset_beeps_seen", exp_beep.size(), 0);
        exp_held = 0;
        per_exp  = 0;
        end_checks("async_reset");

        // Line held low across reset release: one edge at most, no beep
        beep_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        r = cyc;
        edge_q.delete();
        edge_q.push_back(r + 3);
        model(NO_CUT);
        repeat (TAIL) @(posedge clk);
        #1;
        end_checks("low_release");
        check("low_release_count", int'(burst_count), 0);

        // Fresh single-beep burst after reset
        add_beep(5, 6, 4);
        run_phase(TAIL, -1);
        end_checks("fresh");
        check("fresh_count", int'(burst_count), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
